// File: rtl/gf256_inv_iter.sv
// gf256_inv_iter: iterative GF(2^8) multiplicative inverter (AES basis, 0x11B).
// Computes x^254 = x^-1 by repeated squaring and accumulating multiplication,
// sharing one squarer and one multiplier over seven compute cycles; 0 maps to 0.
module gf256_inv_iter (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data
);

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DONE
   } state_t;

   state_t      state;
   logic [7:0]  sq;
   logic [7:0]  acc;
   logic [2:0]  cnt;

   logic [7:0]  sqNext;
   logic [7:0]  accNext;
   logic        accept;

   // Fold bits 14..8 of a carry-less product back into 8 bits using x^8 = x^4+x^3+x+1
   function automatic logic [7:0] gfReduce(input logic [14:0] p);
      logic [14:0] r;
      r = p;
      for (int i = 14; i >= 8; i--) begin
         if (r[i]) begin
            r = r ^ (15'h011B << (i - 8));
         end
      end
      return r[7:0];
   endfunction

   // Full 8x8 carry-less product followed by reduction
   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            p = p ^ ({7'b0, a} << i);
         end
      end
      return gfReduce(p);
   endfunction

   // Squaring is linear in GF(2): spread bit i to bit 2i, then reduce
   function automatic logic [7:0] gfSq(input logic [7:0] a);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         p[2*i] = a[i];
      end
      return gfReduce(p);
   endfunction

   // One square-and-multiply step: next power of two of the operand, folded into the product
   always_comb begin
      sqNext  = gfSq(sq);
      accNext = gfMul(acc, sqNext);
   end

   // Handshake decode; DONE can hand over its slot to a new operand in the same cycle
   assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign out_data  = acc;

   // Control and datapath registers: accept, seven compute steps, then hold result until taken
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sq    <= 8'h00;
         acc   <= 8'h01 ^ 8'h01;
         cnt   <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sq    <= in_data;
                  acc   <= 8'h01;
                  cnt   <= 3'd0;
                  state <= COMPUTE;
               end
            end
            COMPUTE: begin
               sq  <= sqNext;
               acc <= accNext;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd6) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (accept) begin
                  sq    <= in_data;
                  acc   <= 8'h01;
                  cnt   <= 3'd0;
                  state <= COMPUTE;
               end else if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gf256_inv_iter.sv
// tb_gf256_inv_iter: directed bench for the iterative GF(2^8) inverter.
module tb_gf256_inv_iter;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;

   int vectors;
   int miscompares;

   gf256_inv_iter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // Free-running clock, rising edge active
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a hung run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference multiply by shift-and-xtime, independent of the product-then-reduce form
   function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      logic [7:0] y;
      r = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) r = r ^ x;
         y = y >> 1;
         x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      end
      return r;
   endfunction

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic ordy);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance one cycle: pass the active edge, land on the falling edge for sampling/driving
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Accept an operand, verify the exact 7-cycle latency and the result, then drain
   task automatic doOp(input logic [7:0] x, input logic [7:0] expected);
      applyStimulus(1'b1, x, 1'b1);
      checkOutput("op_in_ready", {7'b0, in_ready}, 8'h01);
      tick();
      applyStimulus(1'b0, 8'hAA, 1'b1);
      for (int i = 1; i <= 6; i++) begin
         tick();
         checkOutput("op_early_valid", {7'b0, out_valid}, 8'h00);
      end
      tick();
      checkOutput("op_valid", {7'b0, out_valid}, 8'h01);
      checkOutput("op_data", out_data, expected);
      tick();
      checkOutput("op_drained", {7'b0, out_valid}, 8'h00);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0);

      // Reset then idle
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("rst_out_valid", {7'b0, out_valid}, 8'h00);
         checkOutput("rst_in_ready", {7'b0, in_ready}, 8'h00);
      end
      rst = 1'b0;
      #1;
      checkOutput("idle_in_ready", {7'b0, in_ready}, 8'h01);
      checkOutput("idle_out_valid", {7'b0, out_valid}, 8'h00);

      // Single operations with hand-computed inverses
      doOp(8'h53, 8'hCA);
      doOp(8'h02, 8'h8D);
      doOp(8'h03, 8'hF6);
      doOp(8'hFF, 8'h1C);
      doOp(8'h01, 8'h01);
      doOp(8'h00, 8'h00);

      // Exhaustive back-to-back sweep, one accept every 8 cycles
      applyStimulus(1'b1, 8'h00, 1'b1);
      tick();
      for (int x = 0; x < 256; x++) begin
         for (int i = 1; i <= 6; i++) tick();
         checkOutput("sweep_early_valid", {7'b0, out_valid}, 8'h00);
         tick();
         checkOutput("sweep_valid", {7'b0, out_valid}, 8'h01);
         if (x == 0) checkOutput("sweep_zero", out_data, 8'h00);
         else        checkOutput("sweep_product", refMul(x[7:0], out_data), 8'h01);
         checkOutput("sweep_in_ready", {7'b0, in_ready}, 8'h01);
         if (x == 255) applyStimulus(1'b0, 8'h00, 1'b1);
         else          applyStimulus(1'b1, 8'(x + 1), 1'b1);
         tick();
      end
      checkOutput("sweep_drained", {7'b0, out_valid}, 8'h00);

      // Back-pressure: result held stable for 10 cycles, delivered once
      applyStimulus(1'b1, 8'h53, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 7; i++) tick();
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp_valid", {7'b0, out_valid}, 8'h01);
         checkOutput("bp_data", out_data, 8'hCA);
         checkOutput("bp_in_ready", {7'b0, in_ready}, 8'h00);
         tick();
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("bp_release_ready", {7'b0, in_ready}, 8'h01);
      checkOutput("bp_release_data", out_data, 8'hCA);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("bp_single", {7'b0, out_valid}, 8'h00);
         tick();
      end

      // Busy-ignore: a second operand offered during compute waits for the DONE edge
      applyStimulus(1'b1, 8'h02, 1'b1);
      tick();
      applyStimulus(1'b1, 8'h53, 1'b1);
      for (int i = 1; i <= 6; i++) begin
         checkOutput("busy_in_ready", {7'b0, in_ready}, 8'h00);
         tick();
         checkOutput("busy_early_valid", {7'b0, out_valid}, 8'h00);
      end
      tick();
      checkOutput("busy_first_valid", {7'b0, out_valid}, 8'h01);
      checkOutput("busy_first_data", out_data, 8'h8D);
      checkOutput("busy_accept_ready", {7'b0, in_ready}, 8'h01);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b1);
      for (int i = 1; i <= 6; i++) begin
         tick();
         checkOutput("busy_second_early", {7'b0, out_valid}, 8'h00);
      end
      tick();
      checkOutput("busy_second_valid", {7'b0, out_valid}, 8'h01);
      checkOutput("busy_second_data", out_data, 8'hCA);
      tick();

      // Reset in the middle of a computation; rst with in_valid is not an accept
      applyStimulus(1'b1, 8'hFF, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b1;
      applyStimulus(1'b1, 8'h03, 1'b1);
      #1;
      checkOutput("midrst_in_ready", {7'b0, in_ready}, 8'h00);
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("midrst_idle_ready", {7'b0, in_ready}, 8'h01);
      for (int i = 0; i < 8; i++) begin
         checkOutput("midrst_no_valid", {7'b0, out_valid}, 8'h00);
         tick();
      end
      doOp(8'h03, 8'hF6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
